render_engine: RTL and testbench
================================

Name: render_engine

Overview:
- Back-buffer renderer. It is the consumer side of the swap controller's start_render / render_idle handshake.
- On each start_render pulse it latches the car position and the target buffer. It then raster-fills the whole back buffer: every pixel gets the background colour, or the car colour inside the car rectangle.
- Writes go to the framebuffer write port under wr_ready back-pressure.
- render_idle feeds back to the swap controller, so a swap can only happen on a completed frame.

Parameters:
- H_RES, 320, active pixels per line
- V_RES, 240, active lines per frame
- PIX_W, 8, pixel width (RGB332)
- CAR_W, 16, car rectangle width in pixels
- CAR_H, 24, car rectangle height in lines
- BG_COLOR, 8'h00, background pixel value
- CAR_COLOR, 8'hE0, car pixel value
- ADDR_W, $clog2(H_RES*V_RES), framebuffer word address width

Ports:
- clk_sys  in  1  system clock
- srst  in  1  synchronous active-high reset, clk_sys domain
- start_render  in  1  one-cycle pulse from the swap controller: begin a frame
- back_sel  in  1  buffer to write (inverse of front_sel_sys); sampled on the accepted start
- car_x  in  $clog2(H_RES)  car left edge; sampled on the accepted start
- car_y  in  $clog2(V_RES)  car top edge; sampled on the accepted start
- wr_ready  in  1  framebuffer accepts a write this cycle
- render_idle  out  1  high when no frame is in progress
- wr_en  out  1  write request
- wr_buf  out  1  buffer select for the write
- wr_addr  out  ADDR_W  linear address y*H_RES+x
- wr_data  out  PIX_W  pixel value
- frame_done  out  1  one-cycle pulse after the last write is accepted
- start_overrun  out  1  one-cycle pulse when start_render arrives while busy

Behaviour:
- Reset values:
  - render_idle=1
  - wr_en=0, wr_buf=0, wr_addr=0, wr_data=0
  - frame_done=0, start_overrun=0
  - state=IDLE, all counters 0
- All outputs are registered.
- IDLE:
  - On start_render, latch back_sel, car_x and car_y; clear x, y and addr to 0; go to FILL.
  - Next cycle render_idle=0.
- FILL:
  - wr_en=1 every cycle.
  - Data is CAR_COLOR when car_x <= x < car_x+CAR_W and car_y <= y < car_y+CAR_H; otherwise BG_COLOR.
  - Edge compares use one extra bit so the car is clipped at the right and bottom edges with no wrap.
  - A write is accepted on a cycle with wr_en && wr_ready.
  - On accept: x increments. At x=H_RES-1, x goes to 0 and y increments. addr increments by 1 on every accept.
  - Stall rule: while wr_en && !wr_ready, addr, data and buf hold stable.
  - The first wr_en is asserted the cycle after render_idle falls, i.e. 2 cycles after start_render.
- Frame end:
  - When the write at (H_RES-1, V_RES-1) is accepted, go to DONE.
  - Exactly H_RES*V_RES accepts per frame.
- DONE (1 cycle): wr_en=0, frame_done=1, render_idle=1 on the following cycle, return to IDLE.
  - Minimum frame time is H_RES*V_RES+3 cycles when wr_ready is held at 1.
- start_render while not IDLE:
  - Ignored: no restart and no latch update.
  - start_overrun pulses the next cycle.
- start_render coincident with the DONE cycle: treated as busy and flagged as an overrun.
- Latched inputs are held for the whole frame. Changes on car_x, car_y or back_sel mid-frame have no effect.
- Reset mid-frame: the cycle after srst, the reset values above hold. No partial-frame completion pulse is produced.
- car_x/car_y beyond the screen edge: the visible part is clipped. A position fully off-screen yields an all-background frame.

Decomposition:
- render_pkg holds:
  - typedef pixel_t (logic [PIX_W-1:0])
  - typedef enum render_state_t {IDLE, FILL, DONE}
  - default colour constants BG_COLOR_DEF and CAR_COLOR_DEF
- One sub-module: raster_scan_ctr.
  - Holds the x/y/addr counters with advance, clear and a last-pixel flag.
  - Parameterised by H_RES and V_RES.
  - Reusable later by a scanout-side reader.

Test Plan:
- Bench uses H_RES=8, V_RES=4, CAR_W=2, CAR_H=2, wr_ready held at 1.
- Basic frame: srst then start_render with car=(3,1), back_sel=1 -> render_idle falls at +1 and first wr_en at +2. There are 32 writes with wr_buf=1 and addr 0..31. CAR_COLOR appears exactly at addr 11,12,19,20. frame_done pulses once and render_idle=1 after.
- Back-pressure: wr_ready low on every third cycle -> still 32 accepts with addr sequence 0..31 and no skips or duplicates. addr and data are stable across each stall cycle.
- Clipping: car=(7,3) -> only addr 31 is CAR_COLOR. car=(7,0) -> addr 7 and 15 are CAR_COLOR.
- Overrun: start_render at write #10 with new car=(0,0) -> start_overrun pulses once. The frame completes using the original position, and only one frame_done is produced.
- Mid-frame reset: srst asserted at write #5 -> next cycle wr_en=0 and render_idle=1, with no frame_done. A following start_render produces a clean frame from addr 0.
- Back-to-back: a second start_render 1 cycle after frame_done, with back_sel=0 -> a full second frame is written with wr_buf=0.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types and default colours for the back-buffer renderer.
package render_pkg;

    localparam int unsigned PIX_W_DEF = 8;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } render_state_t;

    localparam pixel_t BG_COLOR_DEF  = 8'h00;
    localparam pixel_t CAR_COLOR_DEF = 8'hE0;

endpackage

// File: rtl/raster_scan_ctr.sv
// Raster x/y/linear-address counters with clear, advance and last-pixel flag.
module raster_scan_ctr #(
    parameter int unsigned H_RES  = 320,
    parameter int unsigned V_RES  = 240,
    parameter int unsigned ADDR_W = $clog2(H_RES * V_RES)
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       clear,
    input  logic                       advance,
    output logic [$clog2(H_RES)-1:0]   x,
    output logic [$clog2(V_RES)-1:0]   y,
    output logic [ADDR_W-1:0]          addr,
    output logic                       last
);

    localparam int unsigned XW = $clog2(H_RES);
    localparam int unsigned YW = $clog2(V_RES);

    logic x_end;
    logic y_end;

    assign x_end = (x == XW'(H_RES - 1));
    assign y_end = (y == YW'(V_RES - 1));
    assign last  = x_end && y_end;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            x <= x_end ? '0 : x + 1'b1;
            if (x_end) begin
                y <= y_end ? '0 : y + 1'b1;
            end
            addr <= last ? '0 : addr + 1'b1;
        end
    end

endmodule

// File: rtl/render_engine.sv
// Back-buffer renderer: raster-fills one frame per accepted start_render,
// drawing a car rectangle over the background, under wr_ready back-pressure.
module render_engine
    import render_pkg::*;
#(
    parameter int unsigned       H_RES     = 320,
    parameter int unsigned       V_RES     = 240,
    parameter int unsigned       PIX_W     = PIX_W_DEF,
    parameter int unsigned       CAR_W     = 16,
    parameter int unsigned       CAR_H     = 24,
    parameter logic [PIX_W-1:0]  BG_COLOR  = PIX_W'(BG_COLOR_DEF),
    parameter logic [PIX_W-1:0]  CAR_COLOR = PIX_W'(CAR_COLOR_DEF),
    parameter int unsigned       ADDR_W    = $clog2(H_RES * V_RES)
) (
    input  logic                      clk_sys,
    input  logic                      srst,
    input  logic                      start_render,
    input  logic                      back_sel,
    input  logic [$clog2(H_RES)-1:0]  car_x,
    input  logic [$clog2(V_RES)-1:0]  car_y,
    input  logic                      wr_ready,
    output logic                      render_idle,
    output logic                      wr_en,
    output logic                      wr_buf,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [PIX_W-1:0]          wr_data,
    output logic                      frame_done,
    output logic                      start_overrun
);

    localparam int unsigned XW = $clog2(H_RES);
    localparam int unsigned YW = $clog2(V_RES);
    localparam int unsigned XE = XW + 1;
    localparam int unsigned YE = YW + 1;

    render_state_t      state;
    logic               buf_q;
    logic [XW-1:0]      car_x_q;
    logic [YW-1:0]      car_y_q;
    logic               issued_last;

    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [ADDR_W-1:0]  addr;
    logic               ctr_last;
    logic               ctr_clear;
    logic               load;
    logic               accept;
    logic               in_x;
    logic               in_y;
    logic               in_car;

    // The counters always point at the next pixel to present on the write port.
    raster_scan_ctr #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .clk     (clk_sys),
        .srst    (srst),
        .clear   (ctr_clear),
        .advance (load),
        .x       (x),
        .y       (y),
        .addr    (addr),
        .last    (ctr_last)
    );

    assign ctr_clear = (state == IDLE) && start_render;
    assign accept    = wr_en && wr_ready;
    assign load      = (state == FILL) && (!wr_en || (accept && !issued_last));

    // One extra bit so car_x + CAR_W past the edge clips instead of wrapping.
    assign in_x = ({1'b0, x} >= {1'b0, car_x_q}) &&
                  ({1'b0, x} <  ({1'b0, car_x_q} + XE'(CAR_W)));
    assign in_y = ({1'b0, y} >= {1'b0, car_y_q}) &&
                  ({1'b0, y} <  ({1'b0, car_y_q} + YE'(CAR_H)));
    assign in_car = in_x && in_y;

    always_ff @(posedge clk_sys) begin
        if (srst) begin
            state         <= IDLE;
            buf_q         <= 1'b0;
            car_x_q       <= '0;
            car_y_q       <= '0;
            issued_last   <= 1'b0;
            render_idle   <= 1'b1;
            wr_en         <= 1'b0;
            wr_buf        <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            frame_done    <= 1'b0;
            start_overrun <= 1'b0;
        end else begin
            frame_done    <= 1'b0;
            start_overrun <= start_render && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (start_render) begin
                        buf_q       <= back_sel;
                        car_x_q     <= car_x;
                        car_y_q     <= car_y;
                        render_idle <= 1'b0;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (load) begin
                        wr_en       <= 1'b1;
                        wr_buf      <= buf_q;
                        wr_addr     <= addr;
                        wr_data     <= in_car ? CAR_COLOR : BG_COLOR;
                        issued_last <= ctr_last;
                    end else if (accept && issued_last) begin
                        wr_en      <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    render_idle <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_render_engine.sv
// Self-checking bench for render_engine on an 8x4 screen with a 2x2 car.
module tb_render_engine;
    import render_pkg::*;

    localparam int unsigned H = 8;
    localparam int unsigned V = 4;
    localparam int unsigned NPIX = H * V;
    localparam logic [7:0] BG  = 8'h00;
    localparam logic [7:0] CAR = 8'hE0;

    logic        clk = 1'b0;
    logic        srst;
    logic        start_render;
    logic        back_sel;
    logic [2:0]  car_x;
    logic [1:0]  car_y;
    logic        wr_ready = 1'b1;
    logic        render_idle;
    logic        wr_en;
    logic        wr_buf;
    logic [4:0]  wr_addr;
    pixel_t      wr_data;
    logic        frame_done;
    logic        start_overrun;

    render_engine #(
        .H_RES     (H),
        .V_RES     (V),
        .PIX_W     (8),
        .CAR_W     (2),
        .CAR_H     (2),
        .BG_COLOR  (BG),
        .CAR_COLOR (CAR),
        .ADDR_W    (5)
    ) dut (
        .clk_sys       (clk),
        .srst          (srst),
        .start_render  (start_render),
        .back_sel      (back_sel),
        .car_x         (car_x),
        .car_y         (car_y),
        .wr_ready      (wr_ready),
        .render_idle   (render_idle),
        .wr_en         (wr_en),
        .wr_buf        (wr_buf),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .frame_done    (frame_done),
        .start_overrun (start_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       b;
        logic [4:0] addr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [2:0]  cx;
        logic [1:0]  cy;
        logic        bsel;
        logic        stall;
        int          ovr_at;
        logic [31:0] mask;
        int          exp_ovr;
    } frame_vec_t;

    exp_t       sb_q[$];
    frame_vec_t vecs[6];
    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int ov_cnt = 0;
    int acc_cnt = 0;
    int cyc = 0;
    logic stall_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // wr_ready drops on every third cycle while stalling is enabled.
    always @(posedge clk) begin
        #1;
        wr_ready = stall_en ? ((cyc % 3) != 2) : 1'b1;
        cyc++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (frame_done) fd_cnt++;
        if (start_overrun) ov_cnt++;
        if (wr_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d with empty scoreboard", wr_addr);
            end else begin
                e = sb_q[0];
                check("wr_buf", 32'(wr_buf), 32'(e.b));
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
                if (wr_ready) begin
                    void'(sb_q.pop_front());
                    acc_cnt++;
                end
            end
        end
    end

    task automatic push_frame(input logic bsel, input logic [31:0] mask);
        for (int a = 0; a < int'(NPIX); a++) begin
            exp_t e;
            e.b    = bsel;
            e.addr = a[4:0];
            e.data = mask[a] ? CAR : BG;
            sb_q.push_back(e);
        end
    endtask

    // Called and returns at posedge+1; returns in the cycle after frame_done.
    task automatic run_frame(input frame_vec_t v);
        int n;
        int fd0;
        int ov0;
        int acc0;
        logic ovr_done;
        check("idle_before_start", 32'(render_idle), 32'd1);
        push_frame(v.bsel, v.mask);
        fd0 = fd_cnt;
        ov0 = ov_cnt;
        acc0 = acc_cnt;
        ovr_done = 1'b0;
        stall_en = v.stall;
        back_sel = v.bsel;
        car_x = v.cx;
        car_y = v.cy;
        start_render = 1'b1;
        @(posedge clk); #1;
        start_render = 1'b0;
        check("idle_fall_at_+1", 32'(render_idle), 32'd0);
        check("no_wr_en_at_+1", 32'(wr_en), 32'd0);
        @(posedge clk); #1;
        check("wr_en_at_+2", 32'(wr_en), 32'd1);
        n = 0;
        while (fd_cnt == fd0 && n < 400) begin
            if (v.ovr_at != 0 && !ovr_done && (acc_cnt - acc0) == v.ovr_at) begin
                start_render = 1'b1;
                car_x = 3'd0;
                car_y = 2'd0;
                back_sel = ~v.bsel;
                ovr_done = 1'b1;
            end else begin
                start_render = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start_render = 1'b0;
        stall_en = 1'b0;
        check("frame_done_count", 32'(fd_cnt - fd0), 32'd1);
        check("accept_count", 32'(acc_cnt - acc0), 32'(NPIX));
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("overrun_count", 32'(ov_cnt - ov0), 32'(v.exp_ovr));
        check("idle_after_done", 32'(render_idle), 32'd1);
        check("frame_done_single", 32'(frame_done), 32'd0);
        check("wr_en_off_after", 32'(wr_en), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        int n;
        int fd0;
        int acc0;

        //            cx    cy    bsel  stall ovr  mask            exp_ovr
        vecs[0] = '{3'd3, 2'd1, 1'b1, 1'b0, 0,  32'h0018_1800, 0};  // basic
        vecs[1] = '{3'd3, 2'd1, 1'b1, 1'b1, 0,  32'h0018_1800, 0};  // back-pressure
        vecs[2] = '{3'd7, 2'd3, 1'b0, 1'b0, 0,  32'h8000_0000, 0};  // clip corner
        vecs[3] = '{3'd7, 2'd0, 1'b1, 1'b0, 0,  32'h0000_8080, 0};  // clip right
        vecs[4] = '{3'd3, 2'd1, 1'b1, 1'b0, 10, 32'h0018_1800, 1};  // overrun
        vecs[5] = '{3'd0, 2'd0, 1'b0, 1'b0, 0,  32'h0000_0303, 0};  // back-to-back

        srst = 1'b1;
        start_render = 1'b0;
        back_sel = 1'b0;
        car_x = '0;
        car_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_render_idle", 32'(render_idle), 32'd1);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_buf", 32'(wr_buf), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_start_overrun", 32'(start_overrun), 32'd0);
        srst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i]);
        end

        // Reset at write #5: outputs return to reset values, no frame_done.
        repeat (2) @(posedge clk);
        #1;
        push_frame(1'b1, 32'h0018_1800);
        fd0 = fd_cnt;
        acc0 = acc_cnt;
        back_sel = 1'b1;
        car_x = 3'd3;
        car_y = 2'd1;
        start_render = 1'b1;
        @(posedge clk); #1;
        start_render = 1'b0;
        n = 0;
        while ((acc_cnt - acc0) < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reset_reached_write5", 32'(acc_cnt - acc0), 32'd5);
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        sb_q.delete();
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_render_idle", 32'(render_idle), 32'd1);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        check("midrst_no_writes", 32'(wr_en), 32'd0);
        run_frame(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
